// File: rtl/sal_pkg.sv
// Shared definitions for the SAL read-response path: AXI response code and
// the read-burst tag record that travels from the scheduler to the R channel.
package sal_pkg;

  // AXI RRESP value used for every returned beat
  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Tag ID width carried in the tag record; keep equal to the ID_W parameter
  // of sal_rd_resp_buf so no ID bits are lost.
  localparam int SAL_ID_W  = 4;
  localparam int SAL_LEN_W = 4;

  // One outstanding read burst: AXI ID and beat count minus one
  typedef struct packed {
    logic [SAL_ID_W-1:0]  id;
    logic [SAL_LEN_W-1:0] len;
  } sal_tag_t;

endpackage

// File: rtl/sal_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers and an occupancy count.
// A push into a full FIFO is accepted only if a pop happens the same cycle.
module sal_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  // Pointers wrap modulo 2*DEPTH; full when the wrap bits differ and the
  // addresses match.
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty = (r_wptr == r_rptr);
  assign w_pop   = i_pop && !w_empty;
  assign w_push  = i_push && (!w_full || w_pop);

  // Pointer update; reset is active-high and asynchronous
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr[AW-1:0]];
  assign o_full  = w_full;
  assign o_count = r_wptr - r_rptr;

endmodule

// File: rtl/sal_rd_resp_buf.sv
// Read-response buffer: pairs DFI read-data beats with burst tags pushed by
// the scheduler and replays them on an AXI R channel with backpressure.
// Optional feature macro: SAL_RBUF_BYPASS_EN -- when defined, a beat arriving
// at an empty data FIFO with a tag waiting is presented on R the same cycle.
module sal_rd_resp_buf
  import sal_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int ID_W      = 4,
  parameter int DEPTH     = 16,
  parameter int TAG_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tag_valid,
  output logic                     tag_ready,
  input  logic [ID_W-1:0]          tag_id,
  input  logic [3:0]               tag_len,
  input  logic                     dfi_rddata_valid,
  input  logic [DATA_W-1:0]        dfi_rddata,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [ID_W-1:0]          rid,
  output logic [DATA_W-1:0]        rdata,
  output logic [1:0]               rresp,
  output logic                     rlast,
  output logic [$clog2(DEPTH):0]   free_cnt,
  output logic                     overflow_err
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int TCW = $clog2(TAG_DEPTH) + 1;
  localparam int TW  = $bits(sal_tag_t);

  sal_tag_t          w_tag_in;
  sal_tag_t          w_tag_head;
  logic [TW-1:0]     w_tag_q;
  logic              w_tag_full;
  logic [TCW-1:0]    w_tag_cnt;
  logic              w_tag_empty;
  logic              w_tag_push;
  logic              w_tag_pop;

  logic [DATA_W-1:0] w_dat_q;
  logic [DATA_W-1:0] w_head_data;
  logic              w_dat_full;
  logic [CW-1:0]     w_dat_cnt;
  logic [CW-1:0]     w_dat_cnt_nxt;
  logic              w_dat_empty;
  logic              w_dat_push;
  logic              w_dat_pop;
  logic              w_drop;
  logic              w_byp;

  logic              w_rvalid;
  logic              w_hs;
  logic              w_last;

  logic [3:0]        r_beat_cnt;
  logic [CW-1:0]     r_free_cnt;
  logic              r_overflow;

  // Tag side: no tags are accepted while reset is asserted
  assign w_tag_in    = '{id: SAL_ID_W'(tag_id), len: tag_len};
  assign tag_ready   = !rst_n && !w_tag_full;
  assign w_tag_push  = tag_valid && tag_ready;
  assign w_tag_empty = (w_tag_cnt == '0);
  assign w_tag_head  = w_tag_q;
  assign w_dat_empty = (w_dat_cnt == '0);

`ifdef SAL_RBUF_BYPASS_EN
  // Zero-latency path: beat goes straight to R when nothing is queued ahead
  assign w_byp       = !rst_n && w_dat_empty && !w_tag_empty && dfi_rddata_valid;
  assign w_head_data = w_byp ? dfi_rddata : w_dat_q;
`else
  // Registered-only path: R outputs never depend on dfi_rddata combinationally
  assign w_byp       = 1'b0;
  assign w_head_data = w_dat_q;
`endif

  // A beat is only presented once its burst tag has arrived
  assign w_rvalid   = !rst_n && !w_tag_empty && (!w_dat_empty || w_byp);
  assign w_hs       = w_rvalid && rready;
  assign w_last     = (r_beat_cnt == w_tag_head.len);
  assign w_tag_pop  = w_hs && w_last;

  // A bypassed beat consumed on R is never written into the FIFO
  assign w_dat_pop  = w_hs && !w_byp;
  assign w_dat_push = dfi_rddata_valid && !(w_byp && rready);
  assign w_drop     = w_dat_push && w_dat_full && !w_dat_pop;

  assign w_dat_cnt_nxt = w_dat_cnt + CW'(w_dat_push && !w_drop) - CW'(w_dat_pop);

  sal_sync_fifo #(
    .WIDTH (TW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_tag_push),
    .i_wdata (w_tag_in),
    .i_pop   (w_tag_pop),
    .o_rdata (w_tag_q),
    .o_full  (w_tag_full),
    .o_count (w_tag_cnt)
  );

  sal_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_dat_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_dat_push),
    .i_wdata (dfi_rddata),
    .i_pop   (w_dat_pop),
    .o_rdata (w_dat_q),
    .o_full  (w_dat_full),
    .o_count (w_dat_cnt)
  );

  // Beat position within the head burst; restarts at 0 on the last beat
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_beat_cnt <= 4'd0;
    end else if (w_hs) begin
      r_beat_cnt <= w_last ? 4'd0 : r_beat_cnt + 4'd1;
    end
  end

  // Free-entry count tracks the FIFO occupancy as of the same clock edge
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_free_cnt <= CW'(DEPTH);
    end else begin
      r_free_cnt <= CW'(DEPTH) - w_dat_cnt_nxt;
    end
  end

  // Sticky flag for a beat lost to a full FIFO; only reset clears it
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign rvalid       = w_rvalid;
  assign rid          = w_rvalid ? ID_W'(w_tag_head.id) : '0;
  assign rdata        = w_rvalid ? w_head_data : '0;
  assign rlast        = w_rvalid && w_last;
  assign rresp        = RESP_OKAY;
  assign free_cnt     = r_free_cnt;
  assign overflow_err = r_overflow;

endmodule

// File: doc/sal_rd_resp_buf.md
SAL_RD_RESP_BUF -- requirements
Module: sal_rd_resp_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 128, DFI read-data width per clk (64-bit DQ, 2 beats/clk).
REQ-002 SHALL have parameter ID_W, default 4, AXI ID width.
REQ-003 SHALL have parameter DEPTH, default 16, data FIFO entries (power of 2).
REQ-004 SHALL have parameter TAG_DEPTH, default 4, outstanding read-burst tags (power of 2).
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports tag_valid input 1, tag_ready output 1, tag_id input ID_W, tag_len input 4: burst tag pushed by scheduler at READ CAS issue (tag_len = beats-1).
REQ-008 SHALL have ports dfi_rddata_valid input 1, dfi_rddata input DATA_W: PHY read return, no backpressure.
REQ-009 SHALL have ports rvalid output 1, rready input 1, rid output ID_W, rdata output DATA_W, rresp output 2, rlast output 1: AXI R channel.
REQ-010 SHALL have port free_cnt  output  $clog2(DEPTH)+1  free data FIFO entries.
REQ-011 SHALL have port overflow_err  output  1  sticky data-overflow flag.

Function
REQ-012 Tag FIFO SHALL accept on tag_valid&&tag_ready; tag_ready = tag FIFO not full.
REQ-013 Data FIFO SHALL write dfi_rddata on every dfi_rddata_valid unless full and no same-cycle pop.
REQ-014 Full data FIFO with simultaneous pop SHALL accept the push; count unchanged.
REQ-015 dfi_rddata_valid while full without pop SHALL drop the beat and set overflow_err until reset.
REQ-016 Read/write pointers SHALL be $clog2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; full = MSBs differ, low bits equal.
REQ-017 rvalid SHALL be 1 only when data FIFO and tag FIFO both non-empty.
REQ-018 rdata = data FIFO head; rid = head tag_id; rresp = 2'b00 always.
REQ-019 Beat counter (4 bits) SHALL increment per R handshake; rlast = (beat_cnt == head tag_len).
REQ-020 On handshake with rlast: pop tag, clear beat_cnt to 0 same cycle.
REQ-021 rvalid/rid/rdata/rlast SHALL stay stable while rvalid && !rready.
REQ-022 free_cnt = DEPTH - occupancy, registered, updated the cycle after each push/pop.
REQ-023 Data arriving with tag FIFO empty SHALL be stored, not presented.
REQ-024 Minimum latency dfi_rddata_valid -> rvalid: 1 cycle (bypass off).

Reset
REQ-025 While rst_n asserted: pointers, counts, beat_cnt 0; rvalid 0, rlast 0, rid 0, rdata 0, rresp 0, tag_ready 0, overflow_err 0, free_cnt DEPTH held from first cycle after release.
REQ-026 Reset mid-burst SHALL discard all queued tags and data; no partial burst resumes.

Configuration
REQ-027 Macro SAL_RBUF_BYPASS_EN defined: when data FIFO empty, tag present, dfi_rddata_valid=1, rvalid SHALL assert same cycle with rdata=dfi_rddata; if rready, beat not written to FIFO (0-cycle latency).
REQ-028 Macro undefined: no combinational path from dfi_rddata to R outputs; REQ-024 applies.

Structure
REQ-029 sal_pkg SHALL hold RESP_OKAY (2'b00) and the tag struct (id, len) typedef.
REQ-030 One sub-module sal_sync_fifo (parameterised width/depth, count output) SHALL implement both FIFOs.

Verification
REQ-031 Push tag(id=3,len=3); 4 DFI beats 0xA..0xD; rready=1 -> 4 beats rid=3, rlast only on 0xD, rresp=0.
REQ-032 Two tags (id=1,len=1),(id=2,len=0); 3 beats; rready toggling 1/0 -> order id1,id1(last),id2(last), outputs stable while stalled.
REQ-033 rready=0, tag len=15, 17 DFI beats -> free_cnt reaches 0, 17th beat dropped, overflow_err=1 sticky.
REQ-034 Full FIFO, rready=1 and dfi_rddata_valid same cycle -> no drop, free_cnt stays 0, overflow_err=0.
REQ-035 Assert rst_n after 2 of 4 beats delivered -> all outputs 0, free_cnt=16 after release, next tag starts at beat 0.
REQ-036 SAL_RBUF_BYPASS_EN defined, empty FIFO, tag present, rready=1, single beat 0x55 -> rvalid and rdata=0x55 same cycle, free_cnt stays 16.
